// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared constants, FSM state type and ID-width helper for the adder-sharing arbiter.
package adder_arb_pkg;

    localparam int ADDER_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches upward from last+1 with wrap and
// returns the first requester found as a one-hot grant plus its encoded index.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       i_req,
    input  logic [id_w(N)-1:0] i_last,
    output logic [N-1:0]       o_grant,
    output logic [id_w(N)-1:0] o_idx
);

    int j;

    // Walk the search order backwards so the nearest candidate is written last and wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        j       = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(i_last) + k) % N;
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = id_w(N)'(j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin time-sharing of one 11-bit ripple adder between NUM_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the registered carry-out port rsp_ovf.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = ADDER_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_src1,
    input  logic [NUM_REQ*WIDTH-1:0]    req_src2,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_w(NUM_REQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]            rsp_data
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                        rsp_ovf
`endif
);

    localparam int IW = id_w(NUM_REQ);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_fire;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_src2;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_carry;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        req_ready = (r_state == IDLE) ? w_grant : '0;
        w_fire    = |req_ready;
        w_next    = (r_state == IDLE) ? (w_fire ? ADD : IDLE) :
                    (r_state == ADD)  ? HOLD :
                    (rsp_ready ? IDLE : HOLD);
    end

    // Shared ripple-carry adder, carry-in tied low.
    assign w_carry[0] = 1'b0;
    for (genvar g = 0; g < WIDTH; g++) begin : g_rca
        assign w_sum[g] = r_src1[g] ^ r_src2[g] ^ w_carry[g];
        if (g < WIDTH - 1) begin : g_c
            assign w_carry[g+1] = (r_src1[g] & r_src2[g]) | (w_carry[g] & (r_src1[g] ^ r_src2[g]));
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic w_cout;
    assign w_cout = (r_src1[WIDTH-1] & r_src2[WIDTH-1]) |
                    (w_carry[WIDTH-1] & (r_src1[WIDTH-1] ^ r_src2[WIDTH-1]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= IW'(NUM_REQ - 1);
            r_src1    <= '0;
            r_src2    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            r_state   <= w_next;
            rsp_valid <= (w_next == HOLD);
            if (w_fire) begin
                r_last <= w_idx;
                rsp_id <= w_idx;
                r_src1 <= req_src1[w_idx*WIDTH +: WIDTH];
                r_src2 <= req_src2[w_idx*WIDTH +: WIDTH];
            end
            if (r_state == ADD) begin
                rsp_data <= w_sum;
`ifdef ADDER_ARB_OVF_EN
                rsp_ovf  <= w_cout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and randomized checks of the adder arbiter (NUM_REQ = 4)
// against a transaction-level model; honours ADDER_ARB_OVF_EN.
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 11;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_src1;
    logic [N*W-1:0]  req_src2;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
`ifdef ADDER_ARB_OVF_EN
    logic            rsp_ovf;
`endif

    always #5 clk = ~clk;

    adder_share_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] a [N];
    logic [W-1:0] b [N];

    // Transaction model: phase 0 = free, 1 = add in flight, 2 = result offered.
    int m_phase = 0;
    int m_last = N - 1;
    int m_id, m_sum, m_ovf;
    bit m_zero = 1'b1;
    int last_g = -1;
    int cyc = 0;

    int g_id [64];
    int g_cy [64];
    int r_val [64];
    int r_cy [64];
    int r_ov [64];
    int g_n = 0;
    int r_n = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic int gi(input int i);
        return (i < g_n) ? g_id[i] : -1;
    endfunction

    function automatic int ri(input int i);
        return (i < r_n) ? r_val[i] : -1;
    endfunction

    task automatic clear_logs();
        g_n = 0;
        r_n = 0;
    endtask

    task automatic cycle();
        int g, s;
        for (int i = 0; i < N; i++) begin
            req_src1[i*W +: W] = a[i];
            req_src2[i*W +: W] = b[i];
        end
        @(negedge clk);
        g = (m_phase == 0) ? pick(req_valid, m_last) : -1;
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        chk("rsp_valid", int'(rsp_valid), (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_data", int'(rsp_data), m_sum);
`ifdef ADDER_ARB_OVF_EN
            chk("rsp_ovf", int'(rsp_ovf), m_ovf);
`endif
        end
        if (m_zero) begin
            chk("reset_rsp_data", int'(rsp_data), 0);
            chk("reset_rsp_id", int'(rsp_id), 0);
`ifdef ADDER_ARB_OVF_EN
            chk("reset_rsp_ovf", int'(rsp_ovf), 0);
`endif
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i] && g_n < 64) begin
                g_id[g_n] = i;
                g_cy[g_n] = cyc;
                g_n++;
            end
        if (rsp_valid && rsp_ready && r_n < 64) begin
            r_val[r_n] = (int'(rsp_id) << 12) | int'(rsp_data);
            r_cy[r_n]  = cyc;
`ifdef ADDER_ARB_OVF_EN
            r_ov[r_n]  = int'(rsp_ovf);
`else
            r_ov[r_n]  = 0;
`endif
            r_n++;
        end
        last_g = g;
        if (rst) begin
            m_phase = 0;
            m_last  = N - 1;
            m_zero  = 1'b1;
            last_g  = -1;
        end else if (m_phase == 0 && g >= 0) begin
            s       = int'(a[g]) + int'(b[g]);
            m_sum   = s % 2048;
            m_ovf   = s / 2048;
            m_id    = g;
            m_last  = g;
            m_phase = 1;
            m_zero  = 1'b0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && rsp_ready) begin
            m_phase = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit hold);
        repeat (n) begin
            cycle();
            if (!hold && last_g >= 0) req_valid[last_g] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        req_src1 = '0;
        req_src2 = '0;
        @(posedge clk);
        #1;
        run(2, 0);
        rst = 1'b0;
        run(1, 0);

        // single request: 0x123 + 0x045
        clear_logs();
        a[0] = 11'h123; b[0] = 11'h045;
        req_valid = 4'b0001; rsp_ready = 1'b1;
        run(4, 0);
        chk("single_grant", gi(0), 0);
        chk("single_rsp", ri(0), 12'h168);
        chk("single_latency", r_cy[0] - g_cy[0], 2);

        // wrap-around 0x7FF + 0x001
        clear_logs();
        a[1] = 11'h7FF; b[1] = 11'h001;
        req_valid = 4'b0010;
        run(4, 0);
        chk("wrap_rsp", ri(0), (1 << 12) | 0);
`ifdef ADDER_ARB_OVF_EN
        chk("wrap_ovf", r_ov[0], 1);
`endif

        // contention on requesters 0 and 1
        clear_logs();
        a[0] = 11'd1; b[0] = 11'd2; a[1] = 11'd3; b[1] = 11'd4;
        req_valid = 4'b0011;
        run(12, 1);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk("contend_grant", gi(k), k % 2);
            chk("contend_spacing", (k < g_n) ? g_cy[k] - g_cy[0] : -1, 3 * k);
        end
        chk("contend_rsp_count", r_n, 4);
        chk("contend_rsp1", ri(1), (1 << 12) | 7);

        // back-pressure for 5 cycles in HOLD
        clear_logs();
        a[0] = 11'h400; b[0] = 11'h0FF;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        run(2, 0);
        req_valid = 4'b0010;
        run(5, 0);
        chk("bp_no_grant", g_n, 1);
        chk("bp_no_rsp", r_n, 0);
        rsp_ready = 1'b1;
        run(1, 0);
        chk("bp_rsp", ri(0), 12'h4FF);
        chk("bp_accept_cycle", (r_n > 0) ? r_cy[0] - g_cy[0] : -1, 7);
        run(1, 0);
        chk("bp_next_grant", gi(1), 1);
        run(3, 0);

        // reset while the add is in flight
        clear_logs();
        req_valid = 4'b0100;
        run(1, 0);
        rst = 1'b1;
        req_valid = 4'b0011;
        run(1, 1);
        rst = 1'b0;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        run(7, 0);
        chk("rst_first_grant", gi(0), 2);
        chk("rst_after_grant", gi(1), 0);
        chk("rst_rsp_count", r_n, 2);
        chk("rst_rsp0_id", ri(0) >> 12, 0);
        chk("rst_rsp1_id", ri(1) >> 12, 1);

        // four requesters, 1010 after reset (last = 3)
        rst = 1'b1;
        run(1, 1);
        rst = 1'b0;
        clear_logs();
        req_valid = 4'b1010;
        run(9, 1);
        req_valid = '0;
        chk("rr4_g0", gi(0), 1);
        chk("rr4_g1", gi(1), 3);
        chk("rr4_g2", gi(2), 1);
        run(3, 0);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    a[i] = ($urandom_range(3) == 0) ? 11'h7FF : W'($urandom);
                    b[i] = ($urandom_range(3) == 0) ? 11'h7FF : W'($urandom);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(299) == 0);
            run(1, 0);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
